// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, FSM state encoding and register reset values
//               for the operand register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int WIDTH   = 16;
  localparam int NREGS   = 8;
  localparam int FLAGS_W = 5;

  // Power-up operand pair presented to the ALU out of reset.
  localparam logic [15:0] c_reg1_rst = 16'h0001;
  localparam logic [15:0] c_reg2_rst = 16'h7FFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/reg_array.sv
// ============================================================================
// Module      : reg_array
// Description : NREGS x WIDTH register storage, two combinational read ports,
//               one synchronous write port; register 0 is hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_array
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int NREGS = cpu_pkg::NREGS,
  localparam int SELW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [SELW-1:0]  i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [SELW-1:0]  i_raddr_a,
  input  logic [SELW-1:0]  i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b
);

  logic [NREGS-1:0][WIDTH-1:0] w_regs;

  genvar gi;
  for (gi = 0; gi < NREGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign w_regs[gi] = '0;
    end else begin : g_store
      localparam logic [WIDTH-1:0] c_rst_val =
        (gi == 1) ? WIDTH'(c_reg1_rst) :
        (gi == 2) ? WIDTH'(c_reg2_rst) : '0;

      logic [WIDTH-1:0] r_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= c_rst_val;
        end else if (i_we && (i_waddr == SELW'(gi))) begin
          r_q <= i_wdata;
        end
      end

      assign w_regs[gi] = r_q;
    end
  end

  assign o_rdata_a = w_regs[i_raddr_a];
  assign o_rdata_b = w_regs[i_raddr_b];

endmodule

`default_nettype wire

// File: rtl/operand_regfile.sv
// ============================================================================
// Module      : operand_regfile
// Description : Operand register file with a four-state sequencer that fetches
//               ALU operands and writes back either the ALU result or an
//               immediate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_regfile
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int NREGS = cpu_pkg::NREGS,
  localparam int SELW = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic               load,
  input  logic [WIDTH-1:0]   imm,
  input  logic [SELW-1:0]    sel_a,
  input  logic [SELW-1:0]    sel_b,
  input  logic [SELW-1:0]    sel_d,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic [FLAGS_W-1:0] alu_flags,
  output logic [WIDTH-1:0]   r1,
  output logic [WIDTH-1:0]   r2,
  output logic [FLAGS_W-1:0] flags_q,
  output logic               busy,
  output logic               done
);

  state_e             r_state;
  logic               r_done;
  logic [SELW-1:0]    r_sel_a;
  logic [SELW-1:0]    r_sel_b;
  logic [SELW-1:0]    r_sel_d;
  logic               r_load;
  logic [WIDTH-1:0]   r_imm;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [FLAGS_W-1:0] r_flags;

  logic [WIDTH-1:0]   w_rd_a;
  logic [WIDTH-1:0]   w_rd_b;
  logic               w_accept;
  logic               w_we;
  logic [WIDTH-1:0]   w_wdata;

  assign w_accept = (r_state == ST_IDLE) && step;
  assign w_we     = (r_state == ST_WB);
  assign w_wdata  = r_load ? r_imm : alu_out;

  reg_array #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_reg_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_we),
    .i_waddr   (r_sel_d),
    .i_wdata   (w_wdata),
    .i_raddr_a (r_sel_a),
    .i_raddr_b (r_sel_b),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE:  if (step) r_state <= ST_FETCH;
        ST_FETCH: r_state <= r_load ? ST_WB : ST_EXEC;
        ST_EXEC:  r_state <= ST_WB;
        ST_WB: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Request fields are frozen at acceptance so later input changes cannot
  // disturb the operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_a <= '0;
      r_sel_b <= '0;
      r_sel_d <= '0;
      r_load  <= 1'b0;
      r_imm   <= '0;
    end else if (w_accept) begin
      r_sel_a <= sel_a;
      r_sel_b <= sel_b;
      r_sel_d <= sel_d;
      r_load  <= load;
      r_imm   <= imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= WIDTH'(c_reg1_rst);
      r_op_b  <= WIDTH'(c_reg2_rst);
      r_flags <= '0;
    end else begin
      if (r_state == ST_FETCH) begin
        r_op_a <= w_rd_a;
        r_op_b <= w_rd_b;
      end
      if (w_we && !r_load) begin
        r_flags <= alu_flags;
      end
    end
  end

  assign r1      = r_op_a;
  assign r2      = r_op_b;
  assign flags_q = r_flags;
  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;

endmodule

`default_nettype wire
